// File: rtl/nine_segment_pkg.sv
// Shared types and helpers for the nine-segment row-scan controller.
// Contents: scan FSM state type, row index type, frame row bit positions,
// and the 4-bit gamma table used when NINE_SEG_GAMMA_EN is defined.
package nine_segment_pkg;

  localparam int unsigned SEG_W = 9;  // one frame: three rows of three columns
  localparam int unsigned ROW_W = 3;  // columns per row / number of rows

  // Bit position of each row inside a frame word; columns are col2..col0 MSB-first.
  localparam int unsigned ROW2_LSB = 6;
  localparam int unsigned ROW1_LSB = 3;
  localparam int unsigned ROW0_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  typedef logic [1:0] row_idx_t;

  // Perceptual brightness curve: 16 linear codes -> on-step count.
  function automatic logic [3:0] gamma4(input logic [3:0] idx);
    logic [3:0] g;
    case (idx)
      4'd0:    g = 4'd0;
      4'd1:    g = 4'd1;
      4'd2:    g = 4'd1;
      4'd3:    g = 4'd1;
      4'd4:    g = 4'd2;
      4'd5:    g = 4'd2;
      4'd6:    g = 4'd3;
      4'd7:    g = 4'd4;
      4'd8:    g = 4'd5;
      4'd9:    g = 4'd6;
      4'd10:   g = 4'd7;
      4'd11:   g = 4'd8;
      4'd12:   g = 4'd10;
      4'd13:   g = 4'd11;
      4'd14:   g = 4'd13;
      default: g = 4'd15;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/nine_segment_slot_timer.sv
// Row-slot timer: counts 0..SLOT-1 while running, restarts at 0 otherwise.
// Ports: clk_i, rst_i (async, active-high), run_i (advance), bright_i (on-steps);
// combinational flags in_blank_c_o, last_blank_c_o, slot_start_c_o, lit_c_o, slot_end_c_o.
module nine_segment_slot_timer
  import nine_segment_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 2,
  parameter int unsigned STEP_CYCLES = 1,
  parameter int unsigned BRIGHT_W    = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                run_i,
  input  logic [BRIGHT_W-1:0] bright_i,
  output logic                in_blank_c_o,
  output logic                last_blank_c_o,
  output logic                slot_start_c_o,
  output logic                lit_c_o,
  output logic                slot_end_c_o
);

  localparam int unsigned SLOT  = DEAD_CYCLES + ((2 ** BRIGHT_W) - 1) * STEP_CYCLES;
  localparam int unsigned CNT_W = $clog2(SLOT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      on_off_c, on_lim_c;

  // Advance while running, wrap at slot end; hold at 0 when stopped.
  always_comb begin
    cnt_d = '0;
    if (run_i && !slot_end_c_o) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign slot_end_c_o   = (cnt_q == CNT_W'(SLOT - 1));
  assign slot_start_c_o = (cnt_q == '0);
  assign in_blank_c_o   = (cnt_q < CNT_W'(DEAD_CYCLES));
  assign last_blank_c_o = (cnt_q == CNT_W'(DEAD_CYCLES - 1));

  // Offset into the drive window versus the number of lit cycles; the
  // subtraction wraps during dead time, which in_blank masks off.
  assign on_off_c = 32'(cnt_q) - 32'(DEAD_CYCLES);
  assign on_lim_c = 32'(bright_i) * 32'(STEP_CYCLES);
  assign lit_c_o  = !in_blank_c_o && (on_off_c < on_lim_c);

endmodule

// File: rtl/nine_segment_scan_controller.sv
// Row-scan scheduler for a 3x3 common-anode nine-segment LED.
// Frames arrive on a valid/ready handshake into a pending buffer and are
// promoted to the active buffer at the end of the row 0 slot. Each row slot
// starts with DEAD_CYCLES of blanking, then PWM-lit for bright*STEP_CYCLES.
// Ports: clk, reset (async, active-high), enable, frame_data/frame_valid/
// frame_ready, brightness; registered outputs rows (one-hot, active-high),
// cols (active-low), frame_start (pulse at start of row 2 slot).
// Build option: define NINE_SEG_GAMMA_EN to map brightness through gamma4().
module nine_segment_scan_controller
  import nine_segment_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 2,
  parameter int unsigned STEP_CYCLES = 1,
  parameter int unsigned BRIGHT_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [SEG_W-1:0]    frame_data,
  input  logic                frame_valid,
  output logic                frame_ready,
  input  logic [BRIGHT_W-1:0] brightness,
  output logic [ROW_W-1:0]    rows,
  output logic [ROW_W-1:0]    cols,
  output logic                frame_start
);

  scan_state_t         state_q, state_d;
  row_idx_t            row_q, row_d;
  logic [BRIGHT_W-1:0] bright_q, bright_d, bright_eff;
  logic [SEG_W-1:0]    active_q, active_d, pending_q, pending_d;
  logic                pending_full_q, pending_full_d;
  logic                ready_q;
  logic [ROW_W-1:0]    rows_q, rows_d, cols_q, cols_d, seg_row;
  logic                fs_q, fs_d;

  logic in_blank, last_blank, slot_start, lit, slot_end;
  logic running, start, boundary, accept;

  assign running  = enable && (state_q != IDLE);
  assign start    = enable && (state_q == IDLE);
  assign boundary = running && slot_end && (row_q == 2'd0);
  assign accept   = frame_valid && ready_q;

`ifdef NINE_SEG_GAMMA_EN
  // Top four bits index the table; result is left-aligned to BRIGHT_W.
  assign bright_eff = BRIGHT_W'(gamma4(bright_q[BRIGHT_W-1 -: 4])) << (BRIGHT_W - 4);
`else
  assign bright_eff = bright_q;
`endif

  nine_segment_slot_timer #(
    .DEAD_CYCLES(DEAD_CYCLES),
    .STEP_CYCLES(STEP_CYCLES),
    .BRIGHT_W   (BRIGHT_W)
  ) u_timer (
    .clk_i         (clk),
    .rst_i         (reset),
    .run_i         (running),
    .bright_i      (bright_eff),
    .in_blank_c_o  (in_blank),
    .last_blank_c_o(last_blank),
    .slot_start_c_o(slot_start),
    .lit_c_o       (lit),
    .slot_end_c_o  (slot_end)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; dropping enable forces IDLE from anywhere
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = BLANK;
      BLANK:   if (last_blank) state_d = DRIVE;
      DRIVE:   if (slot_end) state_d = BLANK;
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  // Column pattern of the row currently being scanned
  always_comb begin
    seg_row = active_q[ROW0_LSB +: ROW_W];
    case (row_q)
      2'd2:    seg_row = active_q[ROW2_LSB +: ROW_W];
      2'd1:    seg_row = active_q[ROW1_LSB +: ROW_W];
      default: seg_row = active_q[ROW0_LSB +: ROW_W];
    endcase
  end

  // FSM outputs (registered below); enable low blanks on the next edge
  always_comb begin
    rows_d = '0;
    cols_d = '1;
    fs_d   = 1'b0;
    if (enable && (state_q == DRIVE) && lit) begin
      rows_d = ROW_W'(1) << row_q;
      cols_d = ~seg_row;
    end
    if (enable && (state_q == BLANK) && in_blank && slot_start && (row_q == 2'd2)) fs_d = 1'b1;
  end

  // Row sequencing, brightness latch and frame double buffer
  always_comb begin
    row_d = row_q;
    if (!running)     row_d = 2'd2;
    else if (slot_end) row_d = (row_q == 2'd0) ? 2'd2 : row_q - 2'd1;

    bright_d       = (start || boundary) ? brightness : bright_q;
    active_d       = (boundary && pending_full_q) ? pending_q : active_q;
    pending_d      = accept ? frame_data : pending_q;
    pending_full_d = accept || (pending_full_q && !boundary);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q          <= 2'd2;
      bright_q       <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      ready_q        <= 1'b1;
      rows_q         <= '0;
      cols_q         <= '1;
      fs_q           <= 1'b0;
    end else begin
      row_q          <= row_d;
      bright_q       <= bright_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      ready_q        <= !pending_full_d;
      rows_q         <= rows_d;
      cols_q         <= cols_d;
      fs_q           <= fs_d;
    end
  end

  assign frame_ready = ready_q;
  assign rows        = rows_q;
  assign cols        = cols_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_nine_segment_scan_controller.sv
// Directed self-checking bench for nine_segment_scan_controller (default
// parameters: 2 dead cycles, 1 cycle per step, 4-bit brightness, 17-cycle
// slot, 51-cycle frame). Phase p counts output cycles from frame_start.
module tb_nine_segment_scan_controller;

  logic       clk = 1'b0;
  logic       reset, enable, frame_valid, frame_ready, frame_start;
  logic [8:0] frame_data;
  logic [3:0] brightness;
  logic [2:0] rows, cols;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [8:0] FA = 9'b100_010_001;
  localparam logic [8:0] FX = 9'b111_000_101;
  localparam logic [8:0] FB = 9'b011_110_100;

  nine_segment_scan_controller dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .brightness (brightness),
    .rows       (rows),
    .cols       (cols),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Lit cycles per slot for a brightness code.
  function automatic int eff(input int b);
`ifdef NINE_SEG_GAMMA_EN
    int lut [16] = '{0, 1, 1, 1, 2, 2, 3, 4, 5, 6, 7, 8, 10, 11, 13, 15};
    return lut[b];
`else
    return b;
`endif
  endfunction

  // Expected rows/cols at phase p (row 2 slot first, 2 dead cycles per slot).
  function automatic logic [2:0] exp_rows(input int p, input int b);
    int r = 2 - p / 17;
    int c = p % 17;
    if (c >= 2 && (c - 2) < eff(b)) return 3'(1 << r);
    return 3'b000;
  endfunction

  function automatic logic [2:0] exp_cols(input int p, input int b, input logic [8:0] f);
    int r = 2 - p / 17;
    logic [2:0] s = f[3*r +: 3];
    if (exp_rows(p, b) != 3'b000) return ~s;
    return 3'b111;
  endfunction

  task automatic do_reset;
    reset = 1'b1; enable = 1'b0; frame_valid = 1'b0; frame_data = '0; brightness = '0;
    tick; tick;
    reset = 1'b0;
  endtask

  // Reset, load frame f via IDLE handshake, start at brightness b and skip
  // the first (all-zero) frame; the next tick shows phase 0 with f active.
  task automatic prepare(input logic [8:0] f, input int b);
    do_reset;
    frame_data = f; frame_valid = 1'b1;
    tick;
    frame_valid = 1'b0;
    enable = 1'b1; brightness = 4'(b);
    tick;
    repeat (51) tick;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b1; frame_valid = 1'b0; frame_data = '0; brightness = 4'd15;
    tick;
    n_checks++; if (rows !== 3'b000) $display("FAIL reset_rows got %b exp 000", rows); else n_pass++;
    n_checks++; if (cols !== 3'b111) $display("FAIL reset_cols got %b exp 111", cols); else n_pass++;
    n_checks++; if (frame_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", frame_ready); else n_pass++;
    n_checks++; if (frame_start !== 1'b0) $display("FAIL reset_fs got %b exp 0", frame_start); else n_pass++;
    reset = 1'b0; enable = 1'b0;
    tick;
    n_checks++; if ({rows, cols} !== 6'b000_111) $display("FAIL idle_blank got %b exp 000111", {rows, cols}); else n_pass++;
  endtask

  task automatic test_basic;
    logic [7:0] got, exp;
    do_reset;
    frame_data = FA; frame_valid = 1'b1;
    tick;
    n_checks++; if (frame_ready !== 1'b0) $display("FAIL basic_accept_ready got %b exp 0", frame_ready); else n_pass++;
    frame_valid = 1'b0; enable = 1'b1; brightness = 4'd15;
    tick;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 51; p++) begin
        tick;
        got = {rows, cols, frame_start, frame_ready};
        exp = {exp_rows(p, 15), exp_cols(p, 15, (f == 0) ? 9'd0 : FA), (p == 0), !(f == 0 && p < 50)};
        n_checks++;
        if (got !== exp) $display("FAIL basic f=%0d p=%0d got %b exp %b", f, p, got, exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_brightness;
    int bf [4] = '{4, 0, 15, 15};
    int lit;
    logic [6:0] got, exp;
    prepare(FA, 4);
    for (int f = 0; f < 3; f++) begin
      lit = 0;
      for (int p = 0; p < 51; p++) begin
        tick;
        if (rows != 3'b000) lit++;
        got = {rows, cols, frame_start};
        exp = {exp_rows(p, bf[f]), exp_cols(p, bf[f], FA), (p == 0)};
        n_checks++;
        if (got !== exp) $display("FAIL bright f=%0d p=%0d got %b exp %b", f, p, got, exp);
        else n_pass++;
        if (p == 20) brightness = 4'(bf[f+1]);
      end
      n_checks++;
      if (lit != 3 * eff(bf[f])) $display("FAIL bright_count f=%0d got %0d exp %0d", f, lit, 3 * eff(bf[f]));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] fr [3] = '{FX, FA, FB};
    logic       rdy;
    logic [7:0] got, exp;
    prepare(FX, 15);
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < 51; p++) begin
        tick;
        if (f == 0)      rdy = (p <= 5 || p == 50);
        else if (f == 1) rdy = (p == 50);
        else             rdy = 1'b1;
        got = {rows, cols, frame_start, frame_ready};
        exp = {exp_rows(p, 15), exp_cols(p, 15, fr[f]), (p == 0), rdy};
        n_checks++;
        if (got !== exp) $display("FAIL b2b f=%0d p=%0d got %b exp %b", f, p, got, exp);
        else n_pass++;
        if (f == 0 && p == 5) begin frame_data = FA; frame_valid = 1'b1; end
        if (f == 0 && p == 6) frame_data = FB;
        if (f == 1 && p == 0) frame_valid = 1'b0;
      end
    end
  endtask

  task automatic test_boundary_accept;
    logic [8:0] fr [3] = '{FX, FX, FA};
    logic       rdy;
    logic [7:0] got, exp;
    prepare(FX, 15);
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < 51; p++) begin
        tick;
        if (f == 0)      rdy = (p < 50);
        else if (f == 1) rdy = (p == 50);
        else             rdy = 1'b1;
        got = {rows, cols, frame_start, frame_ready};
        exp = {exp_rows(p, 15), exp_cols(p, 15, fr[f]), (p == 0), rdy};
        n_checks++;
        if (got !== exp) $display("FAIL edge_acc f=%0d p=%0d got %b exp %b", f, p, got, exp);
        else n_pass++;
        if (f == 0 && p == 49) begin frame_data = FA; frame_valid = 1'b1; end
        if (f == 0 && p == 50) frame_valid = 1'b0;
      end
    end
  endtask

  task automatic test_enable_drop;
    logic [6:0] got, exp;
    prepare(FA, 15);
    for (int p = 0; p < 26; p++) tick;
    n_checks++;
    if (rows !== 3'b010) $display("FAIL en_pre_row1 got %b exp 010", rows); else n_pass++;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_checks++;
      if ({rows, cols, frame_start} !== 7'b000_111_0) $display("FAIL en_off i=%0d got %b exp 0001110", i, {rows, cols, frame_start});
      else n_pass++;
    end
    enable = 1'b1;
    tick;
    n_checks++;
    if ({rows, cols, frame_start} !== 7'b000_111_0) $display("FAIL en_restart got %b exp 0001110", {rows, cols, frame_start});
    else n_pass++;
    for (int p = 0; p < 51; p++) begin
      tick;
      got = {rows, cols, frame_start};
      exp = {exp_rows(p, 15), exp_cols(p, 15, FA), (p == 0)};
      n_checks++;
      if (got !== exp) $display("FAIL en_resume p=%0d got %b exp %b", p, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] got, exp;
    prepare(FA, 15);
    for (int p = 0; p < 21; p++) begin
      tick;
      if (p == 1) begin frame_data = FX; frame_valid = 1'b1; end
      if (p == 2) frame_valid = 1'b0;
    end
    n_checks++;
    if (rows !== 3'b010) $display("FAIL rst_pre_row1 got %b exp 010", rows); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({rows, cols, frame_start} !== 7'b000_111_0) $display("FAIL rst_async got %b exp 0001110", {rows, cols, frame_start});
    else n_pass++;
    enable = 1'b0;
    tick; tick;
    reset = 1'b0;
    tick;
    n_checks++;
    if (frame_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", frame_ready); else n_pass++;
    enable = 1'b1; brightness = 4'd15;
    tick;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 51; p++) begin
        tick;
        got = {rows, cols, frame_start, frame_ready};
        exp = {exp_rows(p, 15), exp_cols(p, 15, 9'd0), (p == 0), 1'b1};
        n_checks++;
        if (got !== exp) $display("FAIL rst_after f=%0d p=%0d got %b exp %b", f, p, got, exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_gamma;
    int lit = 0;
    prepare(FA, 8);
    for (int p = 0; p < 51; p++) begin
      tick;
      if (rows != 3'b000) lit++;
    end
`ifdef NINE_SEG_GAMMA_EN
    n_checks++;
    if (lit != 15) $display("FAIL gamma8_count got %0d exp 15", lit); else n_pass++;
`else
    n_checks++;
    if (lit != 24) $display("FAIL linear8_count got %0d exp 24", lit); else n_pass++;
`endif
  endtask

  initial begin
    test_reset;
    test_basic;
    test_brightness;
    test_back_to_back;
    test_boundary_accept;
    test_enable_drop;
    test_reset_mid;
    test_gamma;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
